// File: rtl/fpnew_divsqrt_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_divsqrt_iter_core
// Brief    : Radix-2 restoring mantissa divide / square-root iteration engine.
//            Define FPNEW_DIVSQRT_ITER_EARLY_EXIT_EN to finish on zero remainder.
// Revision : 1.0
// ============================================================================
module fpnew_divsqrt_iter_core #(
  parameter  int unsigned MantWidth = 53,
  localparam int unsigned QWidth    = MantWidth + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_start_i,
  input  logic                 sqrt_start_i,
  input  logic                 kill_i,
  input  logic [1:0]           fmt_i,
  input  logic [MantWidth-1:0] mant_a_i,
  input  logic [MantWidth-1:0] mant_b_i,
  input  logic                 exp_odd_i,
  output logic [QWidth-1:0]    quotient_o,
  output logic                 sticky_o,
  output logic                 ready_o,
  output logic                 done_o,
  output logic                 busy_o
);

  // Remainder is kept at the result scale (bit QWidth-1 = 2^0) with two extra
  // integer bits so the square-root partial remainder (< 8) never overflows.
  localparam int unsigned c_REM_W = MantWidth + 4;
  localparam int unsigned c_CNT_W = $clog2(QWidth + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   r_iter;
  logic                 r_sqrt;
  logic [c_REM_W-1:0]   r_rem;
  logic [c_REM_W-1:0]   r_divisor;
  logic [QWidth-1:0]    r_root;
  logic [QWidth-1:0]    r_bit;

  logic [c_CNT_W-1:0]   w_iter;
  logic [c_REM_W-1:0]   w_load_rem;
  logic [c_REM_W-1:0]   w_sub;
  logic [c_REM_W-1:0]   w_diff;
  logic [c_REM_W-1:0]   w_rem_sel;
  logic [c_REM_W-1:0]   w_rem_next;
  logic [QWidth-1:0]    w_root_next;
  logic                 w_ge;
  logic                 w_start;
  logic                 w_last;

  always_comb begin
    w_iter = c_CNT_W'(10);
    unique case (fmt_i)
      2'b00:   w_iter = c_CNT_W'(26);
      2'b01:   w_iter = c_CNT_W'(QWidth);
      2'b10:   w_iter = c_CNT_W'(13);
      default: w_iter = c_CNT_W'(10);
    endcase
  end

  always_comb begin
    w_load_rem = {2'b00, mant_a_i, 2'b00};
    if (!div_start_i && exp_odd_i) w_load_rem = {1'b0, mant_a_i, 3'b000};
  end

  // Sqrt trial is 2*root + 2^-i; the root bits at and below 2^-i are still
  // zero, so OR-ing in the current bit position is an exact addition.
  assign w_sub       = r_sqrt ? ({1'b0, r_root, 1'b0} | {2'b00, r_bit}) : r_divisor;
  assign w_ge        = (r_rem >= w_sub);
  assign w_diff      = r_rem - w_sub;
  assign w_rem_sel   = w_ge ? w_diff : r_rem;
  assign w_rem_next  = w_rem_sel << 1;
  assign w_root_next = w_ge ? (r_root | r_bit) : r_root;
  assign w_start     = (div_start_i | sqrt_start_i) & ~kill_i;

`ifdef FPNEW_DIVSQRT_ITER_EARLY_EXIT_EN
  assign w_last = (r_cnt == (r_iter - c_CNT_W'(1))) || (w_rem_next == '0);
`else
  assign w_last = (r_cnt == (r_iter - c_CNT_W'(1)));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_iter     <= '0;
      r_sqrt     <= 1'b0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_root     <= '0;
      r_bit      <= '0;
      quotient_o <= '0;
      sticky_o   <= 1'b0;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else if (kill_i) begin
      r_state <= S_IDLE;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            // Division wins when both starts are raised together.
            r_state   <= S_BUSY;
            r_cnt     <= '0;
            r_iter    <= w_iter;
            r_sqrt    <= ~div_start_i;
            r_rem     <= w_load_rem;
            r_divisor <= {2'b00, mant_b_i, 2'b00};
            r_root    <= '0;
            r_bit     <= {1'b1, {(QWidth-1){1'b0}}};
            ready_o   <= 1'b0;
            busy_o    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        S_BUSY: begin
          r_cnt  <= r_cnt + c_CNT_W'(1);
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          r_bit  <= r_bit >> 1;
          if (w_last) begin
            r_state    <= S_DONE;
            quotient_o <= w_root_next;
            sticky_o   <= (w_rem_next != '0);
            done_o     <= 1'b1;
            ready_o    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  a_single_start: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ready_o && !kill_i && div_start_i && sqrt_start_i));

endmodule
`default_nettype wire

// File: tb/tb_fpnew_divsqrt_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_divsqrt_iter_core
// Brief    : Self-checking bench for the iterative mantissa divide/sqrt core.
// Revision : 1.0
// ============================================================================
module tb_fpnew_divsqrt_iter_core;

  localparam int MW = 53;
  localparam int QW = 55;
  localparam int NV = 12;

  typedef struct {
    string          name;
    bit             sq;
    logic [1:0]     fmt;
    logic [MW-1:0]  a;
    logic [MW-1:0]  b;
    bit             odd;
    logic [QW-1:0]  q;
    bit             s;
    int             lat;
  } vec_t;

  typedef struct {
    string          name;
    logic [QW-1:0]  q;
    bit             s;
    int             cyc;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          div_start_i;
  logic          sqrt_start_i;
  logic          kill_i;
  logic [1:0]    fmt_i;
  logic [MW-1:0] mant_a_i;
  logic [MW-1:0] mant_b_i;
  logic          exp_odd_i;
  logic [QW-1:0] quotient_o;
  logic          sticky_o;
  logic          ready_o;
  logic          done_o;
  logic          busy_o;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[NV];

  fpnew_divsqrt_iter_core #(.MantWidth(MW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .div_start_i  (div_start_i),
    .sqrt_start_i (sqrt_start_i),
    .kill_i       (kill_i),
    .fmt_i        (fmt_i),
    .mant_a_i     (mant_a_i),
    .mant_b_i     (mant_b_i),
    .exp_odd_i    (exp_odd_i),
    .quotient_o   (quotient_o),
    .sticky_o     (sticky_o),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iter_of(input logic [1:0] f);
    case (f)
      2'b00:   return 26;
      2'b01:   return 55;
      2'b10:   return 13;
      default: return 10;
    endcase
  endfunction

  function automatic logic [127:0] isqrt(input logic [127:0] x);
    logic [127:0] s;
    logic [127:0] c;
    s = '0;
    for (int k = QW - 1; k >= 0; k--) begin
      c = s | (128'd1 << k);
      if (c * c <= x) s = c;
    end
    return s;
  endfunction

  // Reference: exact truncated quotient / integer square root at ITER bits.
  task automatic model(input bit sq, input logic [1:0] f, input logic [MW-1:0] a,
                       input logic [MW-1:0] b, input bit odd,
                       output logic [QW-1:0] q, output bit s, output int lat);
    int            it;
    logic [127:0]  num;
    logic [127:0]  den;
    logic [127:0]  full;
    logic [127:0]  keep;
    logic [QW-1:0] mask;
`ifdef FPNEW_DIVSQRT_ITER_EARLY_EXIT_EN
    logic [QW-1:0] mj;
    logic [127:0]  pre;
    bit            exact;
`endif
    it   = iter_of(f);
    mask = {QW{1'b1}} << (QW - it);
    lat  = it + 1;
    den  = {75'd0, b};
    if (sq) begin
      num  = {75'd0, a} << (odd ? 57 : 56);
      full = isqrt(num);
      q    = full[QW-1:0] & mask;
      keep = {73'd0, q};
      s    = (keep * keep != num);
    end else begin
      num  = {75'd0, a};
      full = (num << (QW - 1)) / den;
      q    = full[QW-1:0] & mask;
      s    = (((num << (it - 1)) % den) != 0);
    end
`ifdef FPNEW_DIVSQRT_ITER_EARLY_EXIT_EN
    for (int j = 0; j < it - 1; j++) begin
      if (sq) begin
        mj    = {QW{1'b1}} << (QW - 1 - j);
        pre   = {73'd0, full[QW-1:0] & mj};
        exact = (pre * pre == num);
      end else begin
        exact = (((num << j) % den) == 0);
      end
      if (exact) begin
        lat = j + 2;
        break;
      end
    end
`endif
  endtask

  task automatic start_op(input bit sq, input logic [1:0] f, input logic [MW-1:0] a,
                          input logic [MW-1:0] b, input bit odd, input string name,
                          input bit push, input logic [QW-1:0] q, input bit s, input int lat);
    sb_t e;
    div_start_i  = !sq;
    sqrt_start_i = sq;
    fmt_i        = f;
    mant_a_i     = a;
    mant_b_i     = b;
    exp_odd_i    = odd;
    if (push) begin
      e.name = name;
      e.q    = q;
      e.s    = s;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    tick();
    div_start_i  = 1'b0;
    sqrt_start_i = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending after %0d cycles, expected 0", sb.size(), limit);
      sb.delete();
    end
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_quotient"}, 64'(quotient_o), 64'(mon_e.q));
        check({mon_e.name, "_sticky"}, 64'(sticky_o), 64'(mon_e.s));
        check({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]   rnd;
    logic [MW-1:0] ta;
    logic [MW-1:0] tb;
    logic [MW-1:0] fm;
    logic [QW-1:0] tq;
    logic [1:0]    f;
    bit            ts;
    bit            sq;
    int            tl;

    rst_i        = 1'b1;
    div_start_i  = 1'b0;
    sqrt_start_i = 1'b0;
    kill_i       = 1'b0;
    fmt_i        = 2'b00;
    mant_a_i     = '0;
    mant_b_i     = '0;
    exp_odd_i    = 1'b0;

    // Hand-derived reference cases.
    vecs[0].name = "fp32_div_1p5_1p0"; vecs[0].sq = 0; vecs[0].fmt = 2'b00;
    vecs[0].a = 53'h18000000000000; vecs[0].b = 53'h10000000000000; vecs[0].odd = 0;
    vecs[0].q = 55'h60000000000000; vecs[0].s = 0;
`ifdef FPNEW_DIVSQRT_ITER_EARLY_EXIT_EN
    vecs[0].lat = 3;
`else
    vecs[0].lat = 27;
`endif
    vecs[1].name = "fp32_div_1p0_1p5"; vecs[1].sq = 0; vecs[1].fmt = 2'b00;
    vecs[1].a = 53'h10000000000000; vecs[1].b = 53'h18000000000000; vecs[1].odd = 0;
    vecs[1].q = 55'h2AAAAAA0000000; vecs[1].s = 1; vecs[1].lat = 27;
    vecs[2].name = "fp64_sqrt_2"; vecs[2].sq = 1; vecs[2].fmt = 2'b01;
    vecs[2].a = 53'h10000000000000; vecs[2].b = '0; vecs[2].odd = 1;
    vecs[2].q = {53'h16A09E667F3BCC, 2'b10}; vecs[2].s = 1; vecs[2].lat = 56;

    // Exact-result cases and random operands use the reference model.
    for (int i = 3; i < NV; i++) begin
      if (i == 3) begin
        sq = 0; f = 2'b10; ta = 53'h1C000000000000; tb = ta; ts = 0;
        vecs[i].name = "fp16_div_equal";
      end else if (i == 4) begin
        sq = 1; f = 2'b01; ta = 53'h10000000000000; tb = '0; ts = 0;
        vecs[i].name = "fp64_sqrt_1";
      end else if (i == 5) begin
        sq = 1; f = 2'b00; ta = 53'h12000000000000; tb = '0; ts = 1;
        vecs[i].name = "fp32_sqrt_2p25";
      end else begin
        sq = bit'(i % 2);
        f  = 2'(i % 4);
        fm = {MW{1'b1}} << (MW - (iter_of(f) - 2));
        rnd = {$urandom(), $urandom()};
        ta  = {1'b1, rnd[51:0]} & fm;
        rnd = {$urandom(), $urandom()};
        tb  = {1'b1, rnd[51:0]} & fm;
        ts  = bit'($urandom_range(0, 1));
        vecs[i].name = $sformatf("rand%0d", i);
      end
      model(sq, f, ta, tb, ts, tq, vecs[i].s, tl);
      vecs[i].sq  = sq;
      vecs[i].fmt = f;
      vecs[i].a   = ta;
      vecs[i].b   = tb;
      vecs[i].odd = ts;
      vecs[i].q   = tq;
      vecs[i].lat = tl;
    end

    repeat (3) tick();
    check("reset_quotient", 64'(quotient_o), 64'd0);
    check("reset_sticky",   64'(sticky_o),   64'd0);
    check("reset_done",     64'(done_o),     64'd0);
    check("reset_busy",     64'(busy_o),     64'd0);
    check("reset_ready",    64'(ready_o),    64'd1);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].sq, vecs[i].fmt, vecs[i].a, vecs[i].b, vecs[i].odd,
               vecs[i].name, 1'b1, vecs[i].q, vecs[i].s, vecs[i].lat);
      wait_drain(100);
    end

    // Back-to-back FP16 divisions: second start on the first done cycle.
    model(0, 2'b10, 53'h18000000000000, 53'h14000000000000, 0, tq, ts, tl);
    start_op(0, 2'b10, 53'h18000000000000, 53'h14000000000000, 0, "b2b_first", 1'b1, tq, ts, tl);
    repeat (tl - 1) tick();
    check("b2b_done_at_restart", 64'(done_o), 64'd1);
    check("b2b_ready_at_restart", 64'(ready_o), 64'd1);
    model(0, 2'b10, 53'h10000000000000, 53'h1C000000000000, 0, tq, ts, tl);
    start_op(0, 2'b10, 53'h10000000000000, 53'h1C000000000000, 0, "b2b_second", 1'b1, tq, ts, tl);
    wait_drain(100);

    // Kill at cycle 5 of an FP64 division.
    start_op(0, 2'b01, 53'h18000000000000, 53'h14000000000000, 0, "killed", 1'b0, '0, 0, 0);
    repeat (4) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_ready", 64'(ready_o), 64'd1);
    check("kill_busy",  64'(busy_o),  64'd0);
    check("kill_done",  64'(done_o),  64'd0);
    repeat (70) tick();

    // Kill together with a start while idle.
    div_start_i = 1'b1;
    kill_i      = 1'b1;
    tick();
    div_start_i = 1'b0;
    kill_i      = 1'b0;
    check("kill_start_busy",  64'(busy_o),  64'd0);
    check("kill_start_ready", 64'(ready_o), 64'd1);
    repeat (30) tick();

    // Asynchronous reset at cycle 8 of an FP32 square root.
    start_op(1, 2'b00, 53'h14000000000000, '0, 0, "reset_victim", 1'b0, '0, 0, 0);
    repeat (7) tick();
    rst_i = 1'b1;
    #1;
    check("midreset_busy",  64'(busy_o),  64'd0);
    check("midreset_ready", 64'(ready_o), 64'd1);
    check("midreset_done",  64'(done_o),  64'd0);
    tick();
    rst_i = 1'b0;
    repeat (40) tick();
    model(0, 2'b11, 53'h1C000000000000, 53'h18000000000000, 0, tq, ts, tl);
    start_op(0, 2'b11, 53'h1C000000000000, 53'h18000000000000, 0, "fp16alt_after_reset", 1'b1, tq, ts, tl);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
